// File: rtl/fwd_pkg.sv
// Shared types and stage-packet field positions for the operand-forwarding unit.
// Positions are given for the 32-bit layout; field_pos() shifts them for other data widths.
package fwd_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PKG_XLEN   = 32;

  typedef struct packed {
    logic                  valid;
    logic                  is_load;
    logic                  writes_rd;
    logic [REG_ADDR_W-1:0] rd;
    logic [PKG_XLEN-1:0]   data;
  } stage_pkt_t;

  localparam int DATA_MSB   = PKG_XLEN - 1;
  localparam int RD_MSB     = PKG_XLEN + REG_ADDR_W - 1;
  localparam int WRITES_BIT = PKG_XLEN + REG_ADDR_W;
  localparam int LOAD_BIT   = PKG_XLEN + REG_ADDR_W + 1;
  localparam int VALID_BIT  = PKG_XLEN + REG_ADDR_W + 2;

  function automatic int field_pos(input int pos, input int xlen);
    return pos + xlen - PKG_XLEN;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-read-port forwarding select: youngest matching stage, then long-latency
// completion, then register file. Also reports this port's load-use and busy hazards.
module fwd_mux
  import fwd_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int XLEN           = 32
) (
  input  logic [NUM_FWD_STAGES*(XLEN+8)-1:0] stage_i,
  input  logic [REG_ADDR_W-1:0]              rs_i,
  input  logic [XLEN-1:0]                    rs_data_i,
  input  logic                               rs_used_i,
  input  logic                               wb_long_valid_i,
  input  logic [REG_ADDR_W-1:0]              wb_long_rd_i,
  input  logic [XLEN-1:0]                    wb_long_data_i,
  input  logic [31:0]                        busy_i,
  output logic [XLEN-1:0]                    rs_data_o,
  output logic                               load_use_o,
  output logic                               busy_hazard_o
);

  localparam int PW    = XLEN + 8;
  localparam int V_POS = field_pos(VALID_BIT, XLEN);
  localparam int L_POS = field_pos(LOAD_BIT, XLEN);
  localparam int W_POS = field_pos(WRITES_BIT, XLEN);
  localparam int R_POS = field_pos(RD_MSB, XLEN);
  localparam int D_POS = field_pos(DATA_MSB, XLEN);

  logic [NUM_FWD_STAGES-1:0] hit;
  logic [NUM_FWD_STAGES-1:0] is_load;
  logic [XLEN-1:0]           sdata [NUM_FWD_STAGES];
  logic                      wb_hit;

  generate
    for (genvar gi = 0; gi < NUM_FWD_STAGES; gi++) begin : g_stage
      logic [REG_ADDR_W-1:0] rd;
      assign rd          = stage_i[gi*PW + R_POS -: REG_ADDR_W];
      assign sdata[gi]   = stage_i[gi*PW + D_POS -: XLEN];
      assign is_load[gi] = stage_i[gi*PW + L_POS];
      assign hit[gi]     = stage_i[gi*PW + V_POS] && stage_i[gi*PW + W_POS] &&
                           (rd != '0) && (rd == rs_i) && rs_used_i;
    end
  endgenerate

  assign wb_hit = wb_long_valid_i && (wb_long_rd_i != '0) &&
                  (wb_long_rd_i == rs_i) && rs_used_i;

  // Walk from oldest to youngest so the lowest-index match is assigned last.
  always_comb begin
    rs_data_o = rs_data_i;
    if (wb_hit) rs_data_o = wb_long_data_i;
    for (int s = NUM_FWD_STAGES - 1; s >= 0; s--) begin
      if (hit[s]) rs_data_o = sdata[s];
    end
  end

  assign load_use_o    = hit[0] && is_load[0];
  assign busy_hazard_o = rs_used_i && busy_i[rs_i] && !wb_hit;

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding, busy scoreboard for long-latency ops and decode stall.
// Optional FWD_PERF_EN adds saturating stall / load-use cycle counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int XLEN           = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_FWD_STAGES*(XLEN+8)-1:0] stage_i,
  input  logic [NUM_READ_PORTS*5-1:0]        rs_i,
  input  logic [NUM_READ_PORTS*XLEN-1:0]     rs_data_i,
  input  logic [NUM_READ_PORTS-1:0]          rs_used_i,
  input  logic                               issue_valid_i,
  input  logic [REG_ADDR_W-1:0]              issue_rd_i,
  input  logic                               wb_long_valid_i,
  input  logic [REG_ADDR_W-1:0]              wb_long_rd_i,
  input  logic [XLEN-1:0]                    wb_long_data_i,
  output logic [NUM_READ_PORTS*XLEN-1:0]     rs_data_ao,
  output logic                               stall_ao,
  output logic                               load_use_hazard_ao,
  output logic [31:0]                        busy_o
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]                        stall_cycles_o,
  output logic [31:0]                        load_use_cnt_o
`endif
);

  logic [31:0]               busy_q, busy_d;
  logic [NUM_READ_PORTS-1:0] lu_vec, bh_vec;
  logic                      waw;

  generate
    for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
      fwd_mux #(
        .NUM_FWD_STAGES(NUM_FWD_STAGES),
        .XLEN          (XLEN)
      ) u_mux (
        .stage_i        (stage_i),
        .rs_i           (rs_i[gi*5 +: 5]),
        .rs_data_i      (rs_data_i[gi*XLEN +: XLEN]),
        .rs_used_i      (rs_used_i[gi]),
        .wb_long_valid_i(wb_long_valid_i),
        .wb_long_rd_i   (wb_long_rd_i),
        .wb_long_data_i (wb_long_data_i),
        .busy_i         (busy_q),
        .rs_data_o      (rs_data_ao[gi*XLEN +: XLEN]),
        .load_use_o     (lu_vec[gi]),
        .busy_hazard_o  (bh_vec[gi])
      );
    end
  endgenerate

  // WAW looks only at registered busy; a same-cycle completion does not release it.
  assign waw                = issue_valid_i && busy_q[issue_rd_i];
  assign load_use_hazard_ao = |lu_vec;
  assign stall_ao           = (|lu_vec) || (|bh_vec) || waw;

  always_comb begin
    busy_d = busy_q;
    if (wb_long_valid_i) busy_d[wb_long_rd_i] = 1'b0;
    if (issue_valid_i && !stall_ao && (issue_rd_i != '0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

`ifdef FWD_PERF_EN
  logic [31:0] stall_cnt_q, lu_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (stall_ao && !(&stall_cnt_q))        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (load_use_hazard_ao && !(&lu_cnt_q)) lu_cnt_q    <= lu_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign load_use_cnt_o = lu_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: reference model checked every cycle
// plus directed vectors with literal expectations (counters when FWD_PERF_EN).
module tb_fwd_scoreboard;
  localparam int NP   = 2;
  localparam int NS   = 2;
  localparam int XLEN = 32;
  localparam int PW   = XLEN + 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NS*PW-1:0]     stage_v;
  logic [NP*5-1:0]      rs_v;
  logic [NP*XLEN-1:0]   rsd_v;
  logic [NP-1:0]        used_v;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic [NP*XLEN-1:0]   rs_data_ao;
  logic                 stall_ao, lu_ao;
  logic [31:0]          busy_o;
`ifdef FWD_PERF_EN
  logic [31:0]          stall_cycles, lu_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] model_busy = '0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.NUM_READ_PORTS(NP), .NUM_FWD_STAGES(NS), .XLEN(XLEN)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .stage_i           (stage_v),
    .rs_i              (rs_v),
    .rs_data_i         (rsd_v),
    .rs_used_i         (used_v),
    .issue_valid_i     (issue_valid),
    .issue_rd_i        (issue_rd),
    .wb_long_valid_i   (wb_valid),
    .wb_long_rd_i      (wb_rd),
    .wb_long_data_i    (wb_data),
    .rs_data_ao        (rs_data_ao),
    .stall_ao          (stall_ao),
    .load_use_hazard_ao(lu_ao),
    .busy_o            (busy_o)
`ifdef FWD_PERF_EN
    ,
    .stall_cycles_o    (stall_cycles),
    .load_use_cnt_o    (lu_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: newest producer among in-flight stages, then completion bus, then regfile.
  function automatic void exp_port(input int p, output logic [XLEN-1:0] data,
                                   output logic lu, output logic bh);
    logic [4:0]    rs;
    logic          used, found, wbm;
    logic [PW-1:0] pkt;
    rs    = rs_v[p*5 +: 5];
    used  = used_v[p];
    data  = rsd_v[p*XLEN +: XLEN];
    lu    = 1'b0;
    found = 1'b0;
    wbm   = used && wb_valid && (wb_rd != 0) && (wb_rd == rs);
    for (int s = 0; s < NS; s++) begin
      pkt = stage_v[s*PW +: PW];
      if (!found && used && pkt[PW-1] && pkt[PW-3] &&
          (pkt[XLEN+4:XLEN] != 0) && (pkt[XLEN+4:XLEN] == rs)) begin
        found = 1'b1;
        data  = pkt[XLEN-1:0];
        lu    = (s == 0) && pkt[PW-2];
      end
    end
    if (!found && wbm) data = wb_data;
    bh = used && (rs != 0) && model_busy[rs] && !wbm;
  endfunction

  function automatic logic model_stall();
    logic [XLEN-1:0] d;
    logic lu, bh, st;
    st = issue_valid && model_busy[issue_rd];
    for (int p = 0; p < NP; p++) begin
      exp_port(p, d, lu, bh);
      st = st || lu || bh;
    end
    return st;
  endfunction

  always @(posedge clk) begin
    if (rst) model_busy <= '0;
    else begin
      if (wb_valid) model_busy[wb_rd] <= 1'b0;
      if (issue_valid && !model_stall() && issue_rd != 0) model_busy[issue_rd] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [XLEN-1:0] d;
    logic lu, bh, lu_any;
    lu_any = 1'b0;
    for (int p = 0; p < NP; p++) begin
      exp_port(p, d, lu, bh);
      lu_any = lu_any || lu;
      chk($sformatf("model_rs_data[%0d]", p), rs_data_ao[p*XLEN +: XLEN], d);
    end
    chk("model_stall", {31'b0, stall_ao}, {31'b0, model_stall()});
    chk("model_load_use", {31'b0, lu_ao}, {31'b0, lu_any});
    chk("model_busy", busy_o, model_busy);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stage_v = '0; rs_v = '0; rsd_v = '0; used_v = '0;
    issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic set_stage(input int s, input logic v, input logic ld, input logic wr,
                           input logic [4:0] rd, input logic [XLEN-1:0] d);
    stage_v[s*PW +: PW] = {v, ld, wr, rd, d};
  endtask

  task automatic set_port(input int p, input logic [4:0] rs, input logic [XLEN-1:0] d,
                          input logic used);
    rs_v[p*5 +: 5]       = rs;
    rsd_v[p*XLEN +: XLEN] = d;
    used_v[p]            = used;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Idle after reset: pass-through, no stall.
    set_port(0, 5'd1, 32'h100, 1'b0); set_port(1, 5'd2, 32'h200, 1'b0);
    #2;
    chk("idle_rs0", rs_data_ao[31:0], 32'h100);
    chk("idle_rs1", rs_data_ao[63:32], 32'h200);
    chk("idle_stall", {31'b0, stall_ao}, 32'd0);
    chk("reset_busy", busy_o, 32'd0);
    tick();

    // Youngest stage wins; then stage 1; stage beats completion; completion alone.
    set_stage(0, 1, 0, 1, 5'd5, 32'hAAAA0000);
    set_stage(1, 1, 0, 1, 5'd5, 32'h11110000);
    set_port(0, 5'd5, 32'h100, 1'b1);
    #2;
    chk("fwd_stage0", rs_data_ao[31:0], 32'hAAAA0000);
    chk("fwd_no_stall", {31'b0, stall_ao}, 32'd0);
    tick();
    set_stage(0, 0, 0, 1, 5'd5, 32'hAAAA0000);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h77;
    #2 chk("fwd_stage1_over_wb", rs_data_ao[31:0], 32'h11110000);
    tick();
    set_stage(1, 0, 0, 1, 5'd5, 32'h11110000);
    #2 chk("fwd_wb", rs_data_ao[31:0], 32'h77);
    tick();

    // Load-use on port 1, then the same with the source unused.
    idle();
    set_stage(0, 1, 1, 1, 5'd7, 32'hDEAD);
    set_port(1, 5'd7, 32'h200, 1'b1);
    #2;
    chk("lu_stall", {31'b0, stall_ao}, 32'd1);
    chk("lu_flag", {31'b0, lu_ao}, 32'd1);
    tick();
    used_v[1] = 1'b0;
    #2;
    chk("lu_unused_stall", {31'b0, stall_ao}, 32'd0);
    chk("lu_unused_data", rs_data_ao[63:32], 32'h200);
    tick();

    // Divide to x9: stall on busy source until completion forwards it.
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    #2 chk("div_issue_stall", {31'b0, stall_ao}, 32'd0);
    tick();
    issue_valid = 1'b0;
    set_port(0, 5'd9, 32'h300, 1'b1);
    #2;
    chk("div_busy_set", busy_o, 32'h200);
    chk("div_busy_stall", {31'b0, stall_ao}, 32'd1);
    chk("div_busy_not_lu", {31'b0, lu_ao}, 32'd0);
    tick();
    #2 chk("div_busy_stall2", {31'b0, stall_ao}, 32'd1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h1234;
    #2;
    chk("div_wb_data", rs_data_ao[31:0], 32'h1234);
    chk("div_wb_no_stall", {31'b0, stall_ao}, 32'd0);
    chk("div_busy_held", busy_o, 32'h200);
    tick();
    idle();
    #2 chk("div_busy_clear", busy_o, 32'd0);
    tick();

    // WAW: reissue to busy x9 stalls and is not recorded, even with a coinciding completion.
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    #2 chk("waw_stall", {31'b0, stall_ao}, 32'd1);
    tick();
    #1 chk("waw_busy_kept", busy_o, 32'h200);
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h5;
    #1 chk("waw_stall_wb", {31'b0, stall_ao}, 32'd1);
    tick();
    idle();
    #2 chk("waw_issue_ignored", busy_o, 32'd0);
    tick();

    // Set wins over clear on the same register.
    issue_valid = 1'b1; issue_rd = 5'd3;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h9;
    tick();
    idle();
    #2 chk("set_wins", busy_o, 32'h8);
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    idle();
    #2 chk("clear_x3", busy_o, 32'd0);

    // x0 never forwarded and never busy.
    set_stage(0, 1, 0, 1, 5'd0, 32'hFFFFFFFF);
    set_port(0, 5'd0, 32'h55, 1'b1);
    issue_valid = 1'b1; issue_rd = 5'd0;
    #2 chk("x0_no_fwd", rs_data_ao[31:0], 32'h55);
    tick();
    idle();
    #2 chk("x0_not_busy", busy_o, 32'd0);
    tick();

    // Counters over three load-use cycles, then a mid-operation reset.
    rst = 1'b1; tick(); rst = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    idle();
    set_stage(0, 1, 1, 1, 5'd7, 32'h1);
    set_port(1, 5'd7, 32'h0, 1'b1);
    tick(); tick(); tick();
    idle();
    #2;
    chk("pre_rst_busy", busy_o, 32'h1000);
`ifdef FWD_PERF_EN
    chk("perf_stall_3", stall_cycles, 32'd3);
    chk("perf_lu_3", lu_cnt, 32'd3);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("rst_busy", busy_o, 32'd0);
`ifdef FWD_PERF_EN
    chk("perf_stall_0", stall_cycles, 32'd0);
    chk("perf_lu_0", lu_cnt, 32'd0);
`endif
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and hazard unit for the integer pipeline. For each of NUM_READ_PORTS source operands it selects the newest value from NUM_FWD_STAGES in-flight stages, a long-latency completion bus, or the register file. It keeps a registered busy scoreboard for multi-cycle (mul/div) destinations and raises a single decode-stage stall for load-use, busy-source and WAW hazards. It sits between decode/register-read and the execute stage.

## Interface
- NUM_READ_PORTS, 2, source operands checked per cycle (1..4)
- NUM_FWD_STAGES, 2, forwarding stages; index 0 is youngest (EX), index 1 is MEM (1..4)
- XLEN, 32, data width

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- stage_i  in  NUM_FWD_STAGES×(XLEN+8)  stage packets: {valid, is_load, writes_rd, rd[4:0], data[XLEN-1:0]}, MSB first
- rs_i  in  NUM_READ_PORTS×5  source register indices
- rs_data_i  in  NUM_READ_PORTS×XLEN  register-file read data
- rs_used_i  in  NUM_READ_PORTS  source actually consumed
- issue_valid_i  in  1  long-latency op leaving decode this cycle
- issue_rd_i  in  5  its destination
- wb_long_valid_i  in  1  long-latency result valid this cycle
- wb_long_rd_i  in  5  its destination
- wb_long_data_i  in  XLEN  its result
- rs_data_ao  out  NUM_READ_PORTS×XLEN  forwarded operands
- stall_ao  out  1  hold decode this cycle
- load_use_hazard_ao  out  1  stall cause: load in stage 0
- busy_o  out  32  registered scoreboard; bit 0 always 0

## Operation
- Stage match for port p, stage s: stage valid && writes_rd && rd != 0 && rd == rs_i[p] && rs_used_i[p]. x0 never matches, never busy.
- Per-port priority: lowest matching stage index, then wb_long (valid, rd != 0, rd == rs_i[p], used), then rs_data_i.
- Load-use: port matches stage 0 and stage 0 is_load -> load_use_hazard_ao = 1, stall_ao = 1. Data from stage 0 is still driven (don't-care to consumer).
- Busy source: rs_used_i[p] && busy[rs_i[p]] && !(wb_long matches port p) -> stall.
- WAW: issue_valid_i && busy[issue_rd_i] -> stall. Uses registered busy only; a same-cycle completion does not release it.
- Scoreboard next state: clear bit wb_long_rd_i on valid completion; then set bit issue_rd_i if issue_valid_i && !stall_ao && issue_rd_i != 0. Set wins over clear on the same bit.
- Issue while stall_ao = 1 is ignored (not recorded).
- Completion to a non-busy register: forwarded normally, no scoreboard effect.
- Reset: busy_o = 0. All other outputs are combinational; with idle inputs after reset they give rs_data_ao = rs_data_i, stall_ao = 0, load_use_hazard_ao = 0.

## Timing
- Forwarding, stall and hazard outputs are combinational: same cycle as inputs, zero latency.
- busy_o updates one cycle after the issue or completion edge.
- Reset asserted mid-operation clears all busy bits at the next edge. Outstanding long ops are the caller's responsibility.

## Configuration
- FWD_PERF_EN defined: adds outputs stall_cycles_o[31:0] and load_use_cnt_o[31:0].
  - stall_cycles_o increments per cycle with stall_ao = 1.
  - load_use_cnt_o increments per cycle with load_use_hazard_ao = 1.
  - Both counters saturate at 0xFFFF_FFFF and reset to 0.
- FWD_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package fwd_pkg holds:
  - stage_pkt_t typedef
  - field offsets: VALID_BIT, LOAD_BIT, WRITES_BIT, RD_MSB, DATA_MSB
  - REG_ADDR_W = 5
- One sub-module fwd_mux, instantiated per read port by generate. It performs stage/completion matching and priority select, and returns the port's load-use and busy-hazard flags.
- Scoreboard and perf counters live in the top module.

## Test plan
- Stage 0 ALU write x5 = 0xAAAA0000, stage 1 write x5 = 0x11110000, rs_i[0] = 5 used -> rs_data_ao[0] = 0xAAAA0000, no stall.
- Stage 0 load to x7, rs_i[1] = 7 used -> stall_ao = 1, load_use_hazard_ao = 1. Same with rs_used_i[1] = 0 -> no stall.
- Issue div to x9; next cycle rs_i[0] = 9 used -> stall until the wb_long x9 = 0x1234 cycle, which gives rs_data_ao[0] = 0x1234, stall_ao = 0; busy_o[9] clears the following cycle.
- busy x9, issue_valid_i with issue_rd_i = 9 -> stall_ao = 1 and busy unchanged, including a cycle where wb_long x9 coincides.
- Stage 0 writes x0 = 0xFFFF_FFFF, rs_i = 0 used -> rs_data_ao = rs_data_i. Issue to x0 -> busy_o stays 0.
- FWD_PERF_EN: 3 load-use stall cycles, then rst_i for one cycle -> counters read 3/3 before reset, 0/0 after, and busy_o = 0.
